// File: rtl/sr_bank_writer.sv
// sr_bank_writer: drives S/R excitation into an external SR flip-flop bank, verifies by read-back, retries, reports done/err
// Ports: clk, rst (async, active high); wr_valid/wr_data/wr_ready write handshake;
//  q_in bank read-back; s_out/r_out registered excitation; busy in DRIVE/VERIFY;
//  done one-cycle completion pulse; err failure flag held until next accept.
module sr_bank_writer #(
  parameter int WIDTH = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, DRIVE, VERIFY, DONE} state_t;
  localparam logic [3:0] MR = 4'(MAX_RETRY);
  state_t state;
  logic [WIDTH-1:0] target;
  logic [3:0] retry;
  // s and r are built from complementary target bits, so they can never both be 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      target <= '0;
      retry <= '0;
      s_out <= '0;
      r_out <= '0;
      wr_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else
      case (state)
        IDLE: if (wr_valid) begin
          state <= DRIVE;
          target <= wr_data;
          retry <= '0;
          err <= 1'b0;
          s_out <= wr_data & ~q_in;
          r_out <= ~wr_data & q_in;
          wr_ready <= 1'b0;
          busy <= 1'b1;
        end
        DRIVE: begin
          state <= VERIFY;
          s_out <= '0;
          r_out <= '0;
        end
        VERIFY: if (q_in != target && retry < MR) begin
          state <= DRIVE;
          retry <= retry + 4'd1;
          s_out <= target & ~q_in;
          r_out <= ~target & q_in;
        end else begin
          state <= DONE;
          err <= q_in != target;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          wr_ready <= 1'b1;
        end
      endcase
endmodule

// File: tb/tb_sr_bank_writer.sv
// tb_sr_bank_writer: bench for sr_bank_writer against an SR-bank environment and a trajectory model
module tb_sr_bank_writer;
  localparam int MAXR = 2;
  logic clk = 0, rst = 0, wr_valid = 0, wr_ready, busy, done, err;
  logic [3:0] wr_data = 0, q_in, s_out, r_out;
  logic [3:0] bank = 0, stuck = 0;
  int pass = 0, total = 0;
  typedef struct packed {logic [3:0] s, r; logic busy, ready, done, err;} exp_t;
  exp_t eq[$];
  logic err_hold = 0;
  logic [3:0] m_b, m_v;
  sr_bank_writer #(.WIDTH(4), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .q_in(q_in), .s_out(s_out), .r_out(r_out), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bank <= (bank | s_out) & ~r_out;
  assign q_in = bank & ~stuck;
  always @(posedge clk or posedge rst)
    if (rst) begin
      eq.delete();
      err_hold = 0;
    end else if (eq.size() != 0) void'(eq.pop_front());
    else if (wr_valid) begin
      m_b = bank;
      m_v = q_in;
      for (int k = 0; k <= MAXR; k++) begin
        eq.push_back({wr_data & ~m_v, ~wr_data & m_v, 4'b1000});
        m_b = (m_b | (wr_data & ~m_v)) & ~(~wr_data & m_v);
        m_v = m_b & ~stuck;
        eq.push_back({8'h00, 4'b1000});
        if (m_v == wr_data) break;
      end
      err_hold = m_v != wr_data;
      eq.push_back({8'h00, 3'b001, err_hold});
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    else pass++;
  endtask
  task automatic cmp();
    exp_t e;
    e = eq.size() != 0 ? eq[0] : {8'h00, 4'b0100 | {3'b000, err_hold}};
    chk("cycle", {20'h0, s_out, r_out, busy, wr_ready, done, err}, {20'h0, e});
    chk("s_and_r", {28'h0, s_out & r_out}, 0);
  endtask
  task automatic cyc();
    @(negedge clk);
    cmp();
  endtask
  task automatic wr(input logic [3:0] d, es, er, input int edc, end_, input logic ee, input logic [3:0] eqv);
    int dc, nd;
    logic de;
    wr_valid = 1;
    wr_data = d;
    cyc();
    wr_valid = 0;
    chk("s_drive", s_out, es);
    chk("r_drive", r_out, er);
    chk("err_drive", err, 0);
    dc = -1;
    nd = 0;
    de = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_out != 0 || r_out != 0) nd++;
      if (done) begin
        dc = i;
        de = err;
      end
      cyc();
    end
    chk("done_cycle", dc, edc);
    chk("drive_count", nd, end_);
    chk("err_done", de, ee);
    chk("q_after", q_in, eqv);
  endtask
  initial begin
    #2 rst = 1;
    #1 cmp();
    chk("reset_outs", {s_out, r_out, wr_ready, busy, done, err}, 12'b0000_0000_1000);
    cyc();
    cyc();
    rst = 0;
    cyc();
    wr(4'b1010, 4'b1010, 4'b0000, 2, 1, 0, 4'b1010);
    wr(4'b0110, 4'b0100, 4'b1000, 2, 1, 0, 4'b0110);
    wr(4'b0110, 4'b0000, 4'b0000, 2, 0, 0, 4'b0110);
    stuck = 4'b0001;
    cyc();
    wr(4'b0001, 4'b0001, 4'b0110, 6, 3, 1, 4'b0000);
    cyc();
    cyc();
    chk("err_held", err, 1);
    stuck = 0;
    cyc();
    wr(4'b0000, 4'b0000, 4'b0001, 2, 1, 0, 4'b0000);
    wr_valid = 1;
    wr_data = 4'b0011;
    cyc();
    wr_data = 4'b1111;
    chk("s_hold", s_out, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      chk("ready_busy", wr_ready, 0);
      if (i < 2) cyc();
    end
    wr_valid = 0;
    cyc();
    cyc();
    chk("q_ignored", q_in, 4'b0011);
    chk("ready_back", wr_ready, 1);
    wr_valid = 1;
    wr_data = 4'b1100;
    cyc();
    wr_valid = 0;
    chk("s_pre_rst", s_out, 4'b1100);
    chk("r_pre_rst", r_out, 4'b0011);
    #2 rst = 1;
    #1 cmp();
    chk("rst_drive", {s_out, r_out, wr_ready, busy, done, err}, 12'b0000_0000_1000);
    cyc();
    cyc();
    rst = 0;
    cyc();
    chk("q_abandoned", q_in, 4'b0011);
    wr(4'b1100, 4'b1100, 4'b0011, 2, 1, 0, 4'b1100);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
